// File: rtl/keccak_round_scheduler_pkg.sv
// rtl/keccak_round_scheduler_pkg.sv - shared encodings for the Keccak round scheduler
package keccak_round_scheduler_pkg;

  localparam int NUM_STEPS      = 5;
  localparam int ROUNDS_DEFAULT = 24;

  localparam logic [2:0] THETA = 3'd0;
  localparam logic [2:0] RHO   = 3'd1;
  localparam logic [2:0] PI    = 3'd2;
  localparam logic [2:0] CHI   = 3'd3;
  localparam logic [2:0] IOTA  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    FINISH  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  function automatic logic [NUM_STEPS-1:0] step_onehot(input logic [2:0] step);
    return {{(NUM_STEPS-1){1'b0}}, 1'b1} << step;
  endfunction

endpackage

// File: rtl/keccak_mem_arbiter.sv
// rtl/keccak_mem_arbiter.sv - steers the single state-memory port to the selected step engine
module keccak_mem_arbiter
  import keccak_round_scheduler_pkg::*;
#(
  parameter int LINEW = 25,
  parameter int ADDRW = 5
) (
  input  logic [NUM_STEPS-1:0]       sel,
  input  logic [NUM_STEPS-1:0]       step_req,
  input  logic [NUM_STEPS-1:0]       step_we,
  input  logic [NUM_STEPS*ADDRW-1:0] step_addr,
  input  logic [NUM_STEPS*LINEW-1:0] step_wdata,
  output logic [NUM_STEPS-1:0]       mem_gnt,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDRW-1:0]           mem_addr,
  output logic [LINEW-1:0]           mem_wdata
);

  // sel is one-hot or zero, so an AND-OR mux suffices and idles at all-zero
  always_comb begin
    mem_gnt   = sel & step_req;
    mem_en    = |mem_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (mem_gnt[i]) begin
        mem_we    = mem_we    | step_we[i];
        mem_addr  = mem_addr  | step_addr[i*ADDRW +: ADDRW];
        mem_wdata = mem_wdata | step_wdata[i*LINEW +: LINEW];
      end
    end
  end

endmodule

// File: rtl/keccak_round_scheduler.sv
// rtl/keccak_round_scheduler.sv - sequences Theta..Iota engines over ROUNDS rounds with a watchdog
module keccak_round_scheduler
  import keccak_round_scheduler_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEFAULT,
  parameter int LINEW   = 25,
  parameter int ADDRW   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [NUM_STEPS-1:0]       step_start,
  input  logic [NUM_STEPS-1:0]       step_done,
  input  logic [NUM_STEPS-1:0]       step_req,
  input  logic [NUM_STEPS-1:0]       step_we,
  input  logic [NUM_STEPS*ADDRW-1:0] step_addr,
  input  logic [NUM_STEPS*LINEW-1:0] step_wdata,
  output logic [NUM_STEPS-1:0]       mem_gnt,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDRW-1:0]           mem_addr,
  output logic [LINEW-1:0]           mem_wdata,
  output logic [4:0]                 round_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

  state_t               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [4:0]           round_q, round_d;
  logic [7:0]           wdog_q, wdog_d;
  logic [NUM_STEPS-1:0] step_start_q, step_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [NUM_STEPS-1:0] step_oh;
  logic [NUM_STEPS-1:0] arb_sel;

  assign step_oh = step_onehot(step_q);
  assign arb_sel = busy_q ? step_oh : '0;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d = LAUNCH;
          step_d  = THETA;
          round_d = '0;
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      // done from any engine other than the active one is deliberately not looked at
      WAIT: begin
        if (|(step_done & step_oh)) begin
          state_d = ADVANCE;
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == WDOG_LIMIT) begin
            state_d = ERROR;
          end
        end
      end
      ADVANCE: begin
        if (step_q < IOTA) begin
          step_d  = step_q + 3'd1;
          state_d = LAUNCH;
        end else if (round_q < LAST_ROUND) begin
          round_d = round_q + 5'd1;
          step_d  = THETA;
          state_d = LAUNCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = state_d inside {LAUNCH, WAIT, ADVANCE};
    done_d       = (state_d == FINISH);
    err_d        = (state_d == ERROR);
    step_start_d = (state_d == LAUNCH) ? step_onehot(step_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_q       <= THETA;
      round_q      <= '0;
      wdog_q       <= '0;
      step_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      round_q      <= round_d;
      wdog_q       <= wdog_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign step_start = step_start_q;
  assign round_idx  = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  keccak_mem_arbiter #(
    .LINEW(LINEW),
    .ADDRW(ADDRW)
  ) u_mem_arbiter (
    .sel       (arb_sel),
    .step_req  (step_req),
    .step_we   (step_we),
    .step_addr (step_addr),
    .step_wdata(step_wdata),
    .mem_gnt   (mem_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: doc/keccak_round_scheduler.md
KECCAK_ROUND_SCHEDULER -- requirements
Module: keccak_round_scheduler

Interface
REQ-001 Parameter ROUNDS, default 24, number of permutation rounds (range 1..31).
REQ-002 Parameter LINEW, default 25, width of one state-memory line in bits.
REQ-003 Parameter ADDRW, default 5, state-memory address width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for a step done (8-bit).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a permutation.
REQ-008 step_start  output  5  one-hot launch pulse; bit0..4 = Theta, Rho, Pi, Chi, Iota.
REQ-009 step_done  input  5  per-engine completion pulse.
REQ-010 step_req  input  5  per-engine memory request.
REQ-011 step_we  input  5  per-engine write enable.
REQ-012 step_addr  input  5*ADDRW  packed engine addresses, engine i at [i*ADDRW +: ADDRW].
REQ-013 step_wdata  input  5*LINEW  packed engine write data, same packing.
REQ-014 mem_gnt  output  5  one-hot grant to the active engine.
REQ-015 mem_en, mem_we  output  1 each  shared memory port controls.
REQ-016 mem_addr  output  ADDRW  shared memory port address.
REQ-017 mem_wdata  output  LINEW  shared memory port write data.
REQ-018 round_idx  output  5  current round number, 0-based.
REQ-019 busy, done, err  output  1 each  status signals.

Function
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT, ADVANCE, FINISH, ERROR.
REQ-021 IDLE: start=1 -> LAUNCH next cycle, with round_idx=0 and step=Theta; otherwise remain in IDLE.
REQ-022 LAUNCH SHALL assert step_start[step] for exactly one cycle, clear the watchdog, then go to WAIT.
REQ-023 WAIT: step_done[step]=1 -> ADVANCE; step_done bits of non-active engines are ignored.
REQ-024 WAIT: watchdog increments each cycle; reaching TIMEOUT without done -> ERROR.
REQ-025 ADVANCE: step<Iota -> step+1, then LAUNCH.
REQ-026 ADVANCE: step=Iota and round_idx<ROUNDS-1 -> round_idx+1, step=Theta, then LAUNCH.
REQ-027 ADVANCE: step=Iota and round_idx=ROUNDS-1 -> FINISH.
REQ-028 FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-029 ERROR SHALL hold err=1 until start=1, which clears err and behaves as in REQ-021.
REQ-030 busy=1 exactly in LAUNCH, WAIT and ADVANCE.
REQ-031 start while busy SHALL be ignored; no restart and no counter change.
REQ-032 In LAUNCH, WAIT and ADVANCE, mem_gnt = onehot(step) & step_req (combinational); zero in all other states.
REQ-033 mem_en = |mem_gnt; mem_we, mem_addr and mem_wdata come from the granted engine; all zero when no grant.
REQ-034 Requests from non-active engines SHALL never reach the memory port.
REQ-035 Latency start->first step_start: 1 cycle; step_done->next step_start: 2 cycles.
REQ-036 A step_done arriving in the same cycle as its step_start SHALL be ignored.
REQ-037 round_idx SHALL stay stable from LAUNCH through ADVANCE of the same step, for use by the Iota constant lookup.

Reset
REQ-038 rst=0 SHALL immediately force state=IDLE, step=Theta, round_idx=0 and watchdog=0.
REQ-039 During reset, all outputs SHALL be 0: step_start, mem_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy, done, err.
REQ-040 Reset mid-permutation SHALL abort with no done pulse; a later start begins at round 0.

Structure
REQ-041 A shared package SHALL hold the state encoding, the step index constants THETA..IOTA = 0..4, and the ROUNDS default.
REQ-042 The memory mux SHALL be one sub-module, keccak_mem_arbiter: onehot select plus packed engine buses in, single port out.
REQ-043 Round and watchdog counters stay inside the scheduler; no further hierarchy.

Verification
REQ-044 ROUNDS=2, each engine answers done 3 cycles after its start -> 10 step_start pulses in order 0..4,0..4; round_idx goes 0 then 1; single done pulse; busy falls the same cycle done rises.
REQ-045 Pi active, step_req=5'b11111, step_addr[Pi]=7, step_we[Pi]=1 -> mem_gnt=5'b00100, mem_addr=7, mem_we=1.
REQ-046 TIMEOUT=10, Chi never answers -> err=1 at the 10th WAIT cycle; next start clears err and relaunches Theta at round 0.
REQ-047 start pulsed during round 1, plus a spurious step_done[Theta] while Rho is active -> no restart and no step skip.
REQ-048 rst low during round 1 WAIT -> all outputs 0 immediately, no done pulse; restart after reset completes the full ROUNDS.
